addr_amend_fsm: RTL and testbench
=================================

ADDR_AMEND_FSM -- requirements
Module: addr_amend_fsm

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of register data, memory address, offset and data fields.
REQ-002 Parameter SEL_W, default 3, SHALL set the width of register-select fields.
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset (asserted at 0).
REQ-005 regA, regB, regC  input  SEL_W each  SHALL be the decoded operand register indices (A = array id, B = offset, C = value).
REQ-006 reg_data_out  input  DATA_W  SHALL be the register-bank read data for the currently driven select.
REQ-007 mem_out  input  DATA_W  SHALL be the memory read data; it is unused by this block.
REQ-008 reg_in  output  reg_in_bus_t  SHALL drive the register-bank request: sel[SEL_W], data[DATA_W], mode[1] (1 = write, 0 = read).
REQ-009 mem_in  output  mem_in_bus_t  SHALL drive the memory request: mode[2] (00 = read/no-op, 01 = write), address, offset, data [DATA_W each].
REQ-010 finished  output  1  SHALL flag completion of the amendment.

Function
REQ-011 The block SHALL perform mem[R[A]][R[B]] <= R[C] as a Moore FSM with states RD_A, RD_B, RD_C, WRITE, DONE, one clock per state.
REQ-012 Register reads SHALL be combinational: in RD_A/RD_B/RD_C, reg_in.sel = regA/regB/regC and reg_in.mode = 0, with reg_data_out captured on the rising edge leaving the state into addr_q, off_q and data_q respectively.
REQ-013 Transitions SHALL be RD_A->RD_B->RD_C->WRITE->DONE unconditionally; DONE SHALL be absorbing until reset.
REQ-014 In WRITE, mem_in SHALL be mode = 01, address = addr_q, offset = off_q, data = data_q for exactly one cycle; the write commits at the edge leaving WRITE.
REQ-015 In all states other than WRITE, mem_in SHALL be mode = 00, with address, offset and data all 0.
REQ-016 reg_in.mode SHALL be 0 and reg_in.data SHALL be 0 in every state; the block never writes registers.
REQ-017 In WRITE and DONE, reg_in.sel SHALL be 0.
REQ-018 finished SHALL be 1 only in DONE; it rises after the 4th rising edge following reset release.
REQ-019 regA/regB/regC SHALL be used live (not latched); the caller keeps them stable from reset release through WRITE.
REQ-020 Aliased operands (any of A, B, C equal) SHALL read the same register multiple times, with no special handling.
REQ-021 Operand values SHALL pass unmodified, with no arithmetic; address 0 and all-ones values are legal.
REQ-022 Reset asserted in any state SHALL abort immediately; if asserted before the edge leaving WRITE, no memory write occurs.

Reset
REQ-023 While reset = 0, state SHALL be RD_A and addr_q/off_q/data_q SHALL be 0.
REQ-024 While reset = 0, outputs SHALL be: reg_in = {sel = regA, data = 0, mode = 0}; mem_in = {mode = 00, address = 0, offset = 0, data = 0}; finished = 0.
REQ-025 Output changes caused by reset SHALL not wait for a clock edge.

Verification
REQ-026 Basic amend: A=1, B=4, C=2; R1=0xcccc, R4=0x5555, R2=0x5c5c5c5c -> sel sequence 1, 4, 2 with mode 0; then one cycle of mem_in {01, 0xcccc, 0x5555, 0x5c5c5c5c}; finished=1 after edge 4.
REQ-027 Aliasing: A=B=C=3, R3=0x7 -> single write {01, 0x7, 0x7, 0x7}.
REQ-028 Abort: reset driven to 0 during RD_C, then released -> no mem write during the abort; sequence restarts at RD_A and completes normally.
REQ-029 Hold: run 10 cycles past DONE and change regA -> finished stays 1, mem_in.mode stays 00, no further writes.
REQ-030 Async reset: drive reset to 0 mid-cycle in DONE -> finished falls before the next clock edge; outputs match REQ-024.
REQ-031 Every cycle: reg_in.mode = 0, and mem_in.mode = 01 occurs at most once per run.

Source files
------------

// File: rtl/addr_amend_fsm.sv
// Amendment sequencer: reads three operand registers, then issues one memory write
// mem[R[A]][R[B]] <= R[C] and parks in DONE until reset.
package addr_amend_pkg;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 3;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
    logic              mode;  // 1 = write, 0 = read
  } reg_in_bus_t;

  typedef struct packed {
    logic [1:0]        mode;  // 00 = read/no-op, 01 = write
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] data;
  } mem_in_bus_t;

  typedef enum logic [2:0] {
    RD_A  = 3'd0,
    RD_B  = 3'd1,
    RD_C  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;
endpackage

module addr_amend_fsm #(
  parameter int DATA_W = addr_amend_pkg::DATA_W,
  parameter int SEL_W  = addr_amend_pkg::SEL_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SEL_W-1:0]            regA,
  input  logic [SEL_W-1:0]            regB,
  input  logic [SEL_W-1:0]            regC,
  input  logic [DATA_W-1:0]           reg_data_out,
  input  logic [DATA_W-1:0]           mem_out,
  output addr_amend_pkg::reg_in_bus_t reg_in,
  output addr_amend_pkg::mem_in_bus_t mem_in,
  output logic                        finished
);
  import addr_amend_pkg::state_e;
  import addr_amend_pkg::RD_A;
  import addr_amend_pkg::RD_B;
  import addr_amend_pkg::RD_C;
  import addr_amend_pkg::WRITE;
  import addr_amend_pkg::DONE;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] off_q, off_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Memory read data has no role in an amendment; folded into a sink so it stays visible.
  logic unused_mem_out;
  assign unused_mem_out = ^mem_out;

  // NOTE: captured operands are reset too, so a write can never carry stale data from an aborted run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RD_A;
      addr_q  <= '0;
      off_q   <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    off_d    = off_q;
    data_d   = data_q;
    reg_in   = '0;
    mem_in   = '0;
    finished = 1'b0;

    unique case (state_q)
      RD_A: begin
        reg_in.sel = regA;
        addr_d     = reg_data_out;
        state_d    = RD_B;
      end
      RD_B: begin
        reg_in.sel = regB;
        off_d      = reg_data_out;
        state_d    = RD_C;
      end
      RD_C: begin
        reg_in.sel = regC;
        data_d     = reg_data_out;
        state_d    = WRITE;
      end
      WRITE: begin
        mem_in.mode    = 2'b01;
        mem_in.address = addr_q;
        mem_in.offset  = off_q;
        mem_in.data    = data_q;
        state_d        = DONE;
      end
      DONE: begin
        finished = 1'b1;
      end
      default: state_d = RD_A;
    endcase
  end
endmodule

// File: tb/tb_addr_amend_fsm.sv
// Directed bench for addr_amend_fsm: register bank modelled as a small array, memory writes
// counted on the committing clock edge.
module tb_addr_amend_fsm;
  import addr_amend_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        regA, regB, regC;
  logic [31:0]       reg_data_out;
  logic [31:0]       mem_out;
  reg_in_bus_t       reg_in;
  mem_in_bus_t       mem_in;
  logic              finished;

  logic [31:0] rf [8];
  int          total = 0;
  int          bad   = 0;
  int          wr_cnt = 0;
  int          wr_base;

  addr_amend_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .regA         (regA),
    .regB         (regB),
    .regC         (regC),
    .reg_data_out (reg_data_out),
    .mem_out      (mem_out),
    .reg_in       (reg_in),
    .mem_in       (mem_in),
    .finished     (finished)
  );

  always #5 clk = ~clk;

  assign reg_data_out = rf[reg_in.sel];
  assign mem_out      = 32'hdead_beef;

  always @(posedge clk)
    if (reset === 1'b1 && mem_in.mode === 2'b01) wr_cnt++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and apply the every-cycle invariants.
  task automatic step();
    @(negedge clk);
    chk("reg_mode", reg_in.mode, 1'b0);
    chk("reg_data", reg_in.data, 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag, input logic [2:0] a);
    chk({tag, "_reg_in"}, reg_in, {a, 32'h0, 1'b0});
    chk({tag, "_mem_in"}, mem_in, 98'h0);
    chk({tag, "_fin"}, finished, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'h0000_0000;
    rf[1] = 32'h0000_cccc;
    rf[2] = 32'h5c5c_5c5c;
    rf[3] = 32'h0000_0007;
    rf[4] = 32'h0000_5555;
    rf[6] = 32'hffff_ffff;

    // Reset state
    reset = 1'b0; regA = 3'd1; regB = 3'd4; regC = 3'd2;
    step(); step();
    chk_reset_outputs("rst", 3'd1);
    chk("rst_wr", wr_cnt, 0);

    // Basic amend
    reset = 1'b1;
    #1 chk("b_rda_sel", reg_in.sel, 3'd1);
    step(); chk("b_rdb_sel", reg_in.sel, 3'd4);
    chk("b_rdb_mem", mem_in, 98'h0);
    step(); chk("b_rdc_sel", reg_in.sel, 3'd2);
    chk("b_rdc_fin", finished, 1'b0);
    step(); chk("b_wr_mem", mem_in, {2'b01, 32'h0000_cccc, 32'h0000_5555, 32'h5c5c_5c5c});
    chk("b_wr_sel", reg_in.sel, 3'd0);
    chk("b_wr_fin", finished, 1'b0);
    step(); chk("b_done_fin", finished, 1'b1);
    chk("b_done_mem", mem_in, 98'h0);
    chk("b_done_sel", reg_in.sel, 3'd0);
    chk("b_wr_cnt", wr_cnt, 1);

    // Hold in DONE with regA changing
    for (int i = 0; i < 10; i++) begin
      if (i == 4) regA = 3'd5;
      step();
      chk("h_fin", finished, 1'b1);
      chk("h_mode", mem_in.mode, 2'b00);
      chk("h_sel", reg_in.sel, 3'd0);
    end
    chk("h_wr_cnt", wr_cnt, 1);

    // Async reset mid-cycle in DONE
    #2 reset = 1'b0;
    #1 chk_reset_outputs("async", 3'd5);
    step();
    chk_reset_outputs("async_hold", 3'd5);

    // Aliased operands
    regA = 3'd3; regB = 3'd3; regC = 3'd3;
    wr_base = wr_cnt;
    reset = 1'b1;
    #1 chk("al_rda_sel", reg_in.sel, 3'd3);
    step(); step(); step();
    chk("al_wr_mem", mem_in, {2'b01, 32'h7, 32'h7, 32'h7});
    step(); chk("al_done_fin", finished, 1'b1);
    chk("al_wr_cnt", wr_cnt, wr_base + 1);

    // Abort during RD_C
    reset = 1'b0;
    step();
    regA = 3'd1; regB = 3'd4; regC = 3'd2;
    wr_base = wr_cnt;
    reset = 1'b1;
    step(); step();
    chk("ab_rdc_sel", reg_in.sel, 3'd2);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("ab_rst", 3'd1);
    step(); step(); step();
    chk("ab_no_wr", wr_cnt, wr_base);
    reset = 1'b1;
    step(); chk("ab_rdb_sel", reg_in.sel, 3'd4);
    step(); step();
    chk("ab_wr_mem", mem_in, {2'b01, 32'h0000_cccc, 32'h0000_5555, 32'h5c5c_5c5c});
    step(); chk("ab_done_fin", finished, 1'b1);
    chk("ab_wr_cnt", wr_cnt, wr_base + 1);

    // Boundary values: address 0, all-ones offset and data
    reset = 1'b0;
    step();
    regA = 3'd0; regB = 3'd6; regC = 3'd6;
    wr_base = wr_cnt;
    reset = 1'b1;
    step(); step(); step();
    chk("bd_wr_mem", mem_in, {2'b01, 32'h0, 32'hffff_ffff, 32'hffff_ffff});
    step(); chk("bd_done_fin", finished, 1'b1);
    step(); chk("bd_wr_cnt", wr_cnt, wr_base + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
